// File: rtl/ntru_s3_pkg.sv
// rtl/ntru_s3_pkg.sv - shared constants, state type and sizing helper for the S3 vector MAC
package ntru_s3_pkg;

    localparam int W_DEF = 13;

    localparam logic [W_DEF-1:0] S3_ZERO = '0;
    localparam logic [W_DEF-1:0] S3_ONE  = W_DEF'(1);
    localparam logic [W_DEF-1:0] S3_NEG  = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_e;

    function automatic int beats(input int n, input int p);
        return (n + p - 1) / p;
    endfunction

endpackage

// File: rtl/s3_coef_mul.sv
// rtl/s3_coef_mul.sv - single-lane ternary product; any nonzero value other than +1 counts as -1
module s3_coef_mul
    import ntru_s3_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] p
);

    logic a_one;
    logic b_one;

    assign a_one = (a == W'(S3_ONE));
    assign b_one = (b == W'(S3_ONE));

    always_comb begin
        p = '0;
        if (a == '0 || b == '0) begin
            p = '0;
        end else if (a_one == b_one) begin
            p = W'(S3_ONE);
        end else begin
            p = '1;
        end
    end

endmodule

// File: rtl/vector_mul_s3_mac.sv
// rtl/vector_mul_s3_mac.sv - streaming K-channel ternary dot-product MAC with tail mask and result backpressure
module vector_mul_s3_mac
    import ntru_s3_pkg::*;
#(
    parameter int N = 700,
    parameter int P = 7,
    parameter int K = 3,
    parameter int W = W_DEF
) (
    input  logic             clk,
    input  logic             en,
    input  logic             start,
    input  logic             mode,
    input  logic             v_valid,
    output logic             v_ready,
    input  logic [P*W-1:0]   v_data,
    input  logic [K*P*W-1:0] z_data,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [K*W-1:0]   res_data
);

    localparam int BEATS     = beats(N, P);
    localparam int CW        = $clog2(BEATS + 1);
    localparam int TAIL_BASE = (BEATS - 1) * P;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
    logic            mode_q, mode_d;
    logic            flush_cnt_q, flush_cnt_d;
    logic [W-1:0]    prod_q [K*P];
    logic [W-1:0]    prod_d [K*P];
    logic [W-1:0]    acc_q  [K];
    logic [W-1:0]    acc_d  [K];
    logic [W-1:0]    prod   [K*P];

    logic accept;
    logic last_beat;
    logic clear_acc;

    for (genvar k = 0; k < K; k++) begin : g_row
        for (genvar i = 0; i < P; i++) begin : g_lane
            s3_coef_mul #(.W(W)) u_mul (
                .a (v_data[i*W +: W]),
                .b (z_data[(k*P+i)*W +: W]),
                .p (prod[k*P+i])
            );
        end
        assign res_data[k*W +: W] = acc_q[k];
    end

    assign v_ready   = (state_q == RUN);
    assign busy      = (state_q != IDLE);
    assign res_valid = (state_q == DONE);
    assign accept    = v_ready && v_valid;
    assign last_beat = (beat_cnt_q == LAST_BEAT);

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        mode_d      = mode_q;
        flush_cnt_d = flush_cnt_q;
        clear_acc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    beat_cnt_d = '0;
                    mode_d     = mode;
                    clear_acc  = 1'b1;
                end
            end
            RUN: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    if (last_beat) begin
                        state_d     = FLUSH;
                        flush_cnt_d = 1'b0;
                    end
                end
            end
            FLUSH: begin
                flush_cnt_d = 1'b1;
                if (flush_cnt_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage 1: unaccepted cycles and out-of-range tail lanes load zero, so bubbles add nothing.
    always_comb begin
        for (int k = 0; k < K; k++) begin
            for (int i = 0; i < P; i++) begin
                prod_d[k*P+i] = '0;
                if (accept && !(last_beat && (TAIL_BASE + i >= N))) begin
                    prod_d[k*P+i] = prod[k*P+i];
                end
            end
        end
    end

    // Stage 2: per-channel lane sum, then accumulate or deduct, wrapping mod 2^W.
    always_comb begin
        logic [W-1:0] sum;
        sum = '0;
        for (int k = 0; k < K; k++) begin
            sum = '0;
            for (int i = 0; i < P; i++) begin
                sum = sum + prod_q[k*P+i];
            end
            if (clear_acc) begin
                acc_d[k] = '0;
            end else if (mode_q) begin
                acc_d[k] = acc_q[k] - sum;
            end else begin
                acc_d[k] = acc_q[k] + sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            mode_q      <= 1'b0;
            flush_cnt_q <= 1'b0;
            for (int j = 0; j < K*P; j++) prod_q[j] <= '0;
            for (int k = 0; k < K; k++)   acc_q[k]  <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            mode_q      <= mode_d;
            flush_cnt_q <= flush_cnt_d;
            for (int j = 0; j < K*P; j++) prod_q[j] <= prod_d[j];
            for (int k = 0; k < K; k++)   acc_q[k]  <= acc_d[k];
        end
    end

endmodule

// File: tb/tb_vector_mul_s3_mac.sv
// tb/tb_vector_mul_s3_mac.sv - directed self-checking bench for vector_mul_s3_mac
module tb_vector_mul_s3_mac;

    localparam logic [38:0] EXP_ADD  = {13'd0, 13'd7492, 13'd700};
    localparam logic [38:0] EXP_SUB  = {13'd0, 13'd700, 13'd7492};
    localparam logic [23:0] EXP_WRAP = {8'd188, 8'd188, 8'd188};
    localparam logic [38:0] EXP_TAIL = {13'd701, 13'd701, 13'd701};

    int vectors = 0;
    int errors  = 0;

    logic clk = 1'b0;
    logic en  = 1'b1;

    logic         start0 = 0, mode0 = 0, v_valid0 = 0, res_ready0 = 0;
    logic [90:0]  v_data0;
    logic [272:0] z_data0;
    logic         v_ready0, busy0, res_valid0;
    logic [38:0]  res_data0;

    logic         start1 = 0, v_valid1 = 0, res_ready1 = 0;
    logic [55:0]  v_data1;
    logic [167:0] z_data1;
    logic         v_ready1, busy1, res_valid1;
    logic [23:0]  res_data1;

    logic         start2 = 0, v_valid2 = 0, res_ready2 = 0;
    logic [90:0]  v_data2;
    logic [272:0] z_data2;
    logic         v_ready2, busy2, res_valid2;
    logic [38:0]  res_data2;

    always #5 clk = ~clk;

    vector_mul_s3_mac dut0 (
        .clk(clk), .en(en), .start(start0), .mode(mode0),
        .v_valid(v_valid0), .v_ready(v_ready0), .v_data(v_data0), .z_data(z_data0),
        .busy(busy0), .res_valid(res_valid0), .res_ready(res_ready0), .res_data(res_data0)
    );

    vector_mul_s3_mac #(.N(700), .P(7), .K(3), .W(8)) dut1 (
        .clk(clk), .en(en), .start(start1), .mode(1'b0),
        .v_valid(v_valid1), .v_ready(v_ready1), .v_data(v_data1), .z_data(z_data1),
        .busy(busy1), .res_valid(res_valid1), .res_ready(res_ready1), .res_data(res_data1)
    );

    vector_mul_s3_mac #(.N(701), .P(7), .K(3), .W(13)) dut2 (
        .clk(clk), .en(en), .start(start2), .mode(1'b0),
        .v_valid(v_valid2), .v_ready(v_ready2), .v_data(v_data2), .z_data(z_data2),
        .busy(busy2), .res_valid(res_valid2), .res_ready(res_ready2), .res_data(res_data2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_run(input logic m, input int nb, output logic ok);
        start0 = 1'b1;
        mode0  = m;
        tick();
        start0 = 1'b0;
        mode0  = 1'b0;
        ok = busy0 && v_ready0;
        for (int b = 0; b < nb; b++) begin
            v_valid0 = 1'b1;
            tick();
        end
        v_valid0 = 1'b0;
    endtask

    task automatic test_reset();
        en = 1'b1;
        tick();
        tick();
        vectors++; if (v_ready0 !== 1'b0) begin errors++; $display("FAIL reset_v_ready got %b want 0", v_ready0); end
        vectors++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy0); end
        vectors++; if (res_valid0 !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid0); end
        vectors++; if (res_data0 !== 39'd0) begin errors++; $display("FAIL reset_res_data got %h want 0", res_data0); end
        en = 1'b0;
        tick();
    endtask

    task automatic test_mode_add();
        logic ok;
        drive_run(1'b0, 100, ok);
        vectors++; if (ok !== 1'b1) begin errors++; $display("FAIL add_busy_after_start got %b want 1", ok); end
        vectors++; if (res_valid0 !== 1'b0) begin errors++; $display("FAIL add_valid_c1 got %b want 0", res_valid0); end
        tick();
        vectors++; if (res_valid0 !== 1'b0) begin errors++; $display("FAIL add_valid_c2 got %b want 0", res_valid0); end
        tick();
        vectors++; if (res_valid0 !== 1'b1) begin errors++; $display("FAIL add_valid_c3 got %b want 1", res_valid0); end
        vectors++; if (res_data0 !== EXP_ADD) begin errors++; $display("FAIL add_res_data got %h want %h", res_data0, EXP_ADD); end
        res_ready0 = 1'b1;
        tick();
        res_ready0 = 1'b0;
        vectors++; if ({res_valid0, busy0} !== 2'b00) begin errors++; $display("FAIL add_release got %b want 00", {res_valid0, busy0}); end
    endtask

    task automatic test_mode_sub();
        logic ok;
        drive_run(1'b1, 100, ok);
        vectors++; if (ok !== 1'b1) begin errors++; $display("FAIL sub_busy_after_start got %b want 1", ok); end
        tick();
        tick();
        vectors++; if (res_valid0 !== 1'b1) begin errors++; $display("FAIL sub_valid got %b want 1", res_valid0); end
        vectors++; if (res_data0 !== EXP_SUB) begin errors++; $display("FAIL sub_res_data got %h want %h", res_data0, EXP_SUB); end
        res_ready0 = 1'b1;
        tick();
        res_ready0 = 1'b0;
        vectors++; if (busy0 !== 1'b0) begin errors++; $display("FAIL sub_release got %b want 0", busy0); end
    endtask

    task automatic test_stall();
        int n = 0;
        int cyc = 0;
        int t = 0;
        start0 = 1'b1;
        mode0  = 1'b0;
        tick();
        start0 = 1'b0;
        while (n < 100 && cyc < 1000) begin
            v_valid0 = (cyc % 2 == 0);
            start0   = (cyc == 21);
            mode0    = (cyc == 21);
            tick();
            if (v_valid0) n++;
            cyc++;
        end
        v_valid0 = 1'b0;
        start0   = 1'b0;
        mode0    = 1'b0;
        vectors++; if (n !== 100) begin errors++; $display("FAIL stall_beats got %0d want 100", n); end
        while (!res_valid0 && t < 10) begin
            tick();
            t++;
        end
        vectors++; if (t !== 2) begin errors++; $display("FAIL stall_latency got %0d want 2", t); end
        vectors++; if (res_data0 !== EXP_ADD) begin errors++; $display("FAIL stall_res_data got %h want %h", res_data0, EXP_ADD); end
        for (int s = 0; s < 5; s++) begin
            tick();
            vectors++;
            if (res_valid0 !== 1'b1 || res_data0 !== EXP_ADD) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got valid %b data %h want 1 %h", s, res_valid0, res_data0, EXP_ADD);
            end
        end
        res_ready0 = 1'b1;
        tick();
        res_ready0 = 1'b0;
        vectors++; if (res_valid0 !== 1'b0) begin errors++; $display("FAIL stall_release got %b want 0", res_valid0); end
    endtask

    task automatic test_abort();
        logic ok;
        drive_run(1'b0, 50, ok);
        en       = 1'b1;
        v_valid0 = 1'b1;
        tick();
        en       = 1'b0;
        v_valid0 = 1'b0;
        vectors++; if ({v_ready0, busy0, res_valid0} !== 3'b000) begin errors++; $display("FAIL abort_ctrl got %b want 000", {v_ready0, busy0, res_valid0}); end
        vectors++; if (res_data0 !== 39'd0) begin errors++; $display("FAIL abort_res_data got %h want 0", res_data0); end
        drive_run(1'b0, 100, ok);
        tick();
        tick();
        vectors++; if (res_valid0 !== 1'b1) begin errors++; $display("FAIL abort_rerun_valid got %b want 1", res_valid0); end
        vectors++; if (res_data0 !== EXP_ADD) begin errors++; $display("FAIL abort_rerun_data got %h want %h", res_data0, EXP_ADD); end
        res_ready0 = 1'b1;
        tick();
        res_ready0 = 1'b0;
    endtask

    task automatic test_wrap();
        int t = 0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int b = 0; b < 100; b++) begin
            v_valid1 = 1'b1;
            tick();
        end
        v_valid1 = 1'b0;
        while (!res_valid1 && t < 10) begin
            tick();
            t++;
        end
        vectors++; if (res_valid1 !== 1'b1) begin errors++; $display("FAIL wrap_valid got %b want 1", res_valid1); end
        vectors++; if (res_data1 !== EXP_WRAP) begin errors++; $display("FAIL wrap_res_data got %h want %h", res_data1, EXP_WRAP); end
        res_ready1 = 1'b1;
        tick();
        res_ready1 = 1'b0;
    endtask

    task automatic test_tail();
        int t = 0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int b = 0; b < 101; b++) begin
            v_valid2 = 1'b1;
            tick();
        end
        v_valid2 = 1'b0;
        while (!res_valid2 && t < 10) begin
            tick();
            t++;
        end
        vectors++; if (t !== 2) begin errors++; $display("FAIL tail_latency got %0d want 2", t); end
        vectors++; if (res_data2 !== EXP_TAIL) begin errors++; $display("FAIL tail_res_data got %h want %h", res_data2, EXP_TAIL); end
        res_ready2 = 1'b1;
        tick();
        res_ready2 = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 7; i++) begin
            v_data0[i*13 +: 13] = 13'd1;
            v_data1[i*8 +: 8]   = 8'd1;
            v_data2[i*13 +: 13] = 13'd1;
            for (int k = 0; k < 3; k++) begin
                z_data0[(k*7+i)*13 +: 13] = (k == 0) ? 13'd1 : ((k == 1) ? 13'h1fff : 13'd0);
                z_data1[(k*7+i)*8 +: 8]   = 8'd1;
                z_data2[(k*7+i)*13 +: 13] = 13'd1;
            end
        end
        test_reset();
        test_mode_add();
        test_mode_sub();
        test_stall();
        test_abort();
        test_wrap();
        test_tail();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/vector_mul_s3_mac.md
# vector_mul_s3_mac

Parametrised streaming successor to the lift-stage S3 vector multiplier. Computes K dot products, mod 2^W, between one ternary coefficient vector of length N and K caller-supplied ternary rows, consuming P coefficient lanes per beat over a valid/ready stream. Adds a start/done handshake, a tail mask for N not divisible by P, an add/subtract accumulate mode and result backpressure. Sits between the lift datapath and the mod-q polynomial stages.

## Interface
- N, 700: coefficients per vector
- P, 7: lanes per beat; BEATS = ceil(N/P)
- K, 3: channels (rows)
- W, 13: coefficient/accumulator width; q = 2^W
- clk  in  1  clock, rising edge
- en  in  1  synchronous active-high reset; clears all state
- start  in  1  begin a run; sampled only in IDLE
- mode  in  1  latched at start: 0 acc += prod, 1 acc -= prod
- v_valid  in  1  beat valid
- v_ready  out  1  beat accepted when v_valid && v_ready
- v_data  in  P*W  lane i at [i*W +: W], coefficient index beat*P+i
- z_data  in  K*P*W  row k lane i at [(k*P+i)*W +: W], same beat as v_data
- busy  out  1  high from start accept until result taken
- res_valid  out  1  results available
- res_ready  in  1  result consumed when res_valid && res_ready
- res_data  out  K*W  channel k at [k*W +: W]

## Operation
- Ternary encoding: 0 = 0, 1 = +1, 2^W-1 = -1. Product rule per lane: either operand 0 -> 0; both 1 or both 2^W-1 -> 1; otherwise 2^W-1. Any other nonzero value is treated as -1.
- FSM states:
  - IDLE: start -> RUN; clear accumulators, beat_cnt=0, latch mode.
  - RUN: v_ready=1; each accepted beat increments beat_cnt; accept at beat_cnt==BEATS-1 -> FLUSH.
  - FLUSH: 2 cycles draining pipeline -> DONE.
  - DONE: res_valid=1; res_ready -> IDLE.
- Tail mask: on the last beat, lanes with beat*P+i >= N contribute 0 regardless of data.
- Per channel: lane products summed by a P-input adder tree, then added to (mode 0) or subtracted from (mode 1) the accumulator. All arithmetic wraps mod 2^W with no saturation.
- start outside IDLE is ignored. mode is ignored except when start is accepted.
- res_data is held stable while res_valid && !res_ready.

## Timing
- Reset values: v_ready 0, busy 0, res_valid 0, res_data 0, state IDLE, beat_cnt 0.
- en has priority over every other input in the same cycle. en mid-run aborts the run; the next cycle is IDLE with all outputs at reset values.
- Pipeline: stage 1 registers the K*P products (and mask); stage 2 performs adder tree plus accumulate.
- busy rises the cycle after start is accepted.
- res_valid rises 3 cycles after the last beat is accepted.
- Throughput: 1 beat/cycle. Minimum run is BEATS+4 cycles from start to res_valid falling, with res_ready tied high.
- res_valid && res_ready in DONE: res_valid and busy fall next cycle. start is accepted the cycle after returning to IDLE.
- v_valid low in RUN stalls beat_cnt. The pipeline still advances; a bubble stage carries zero products.

## Structure
- Package ntru_s3_pkg holds:
  - W default
  - S3_ZERO, S3_ONE, S3_NEG = 2^W-1
  - state enum {IDLE, RUN, FLUSH, DONE}
  - helper function beats(N,P)
- Sub-module s3_coef_mul: single-lane ternary product (W-bit in x2 -> W-bit), instantiated K*P times.
- Top level holds the FSM, beat counter, tail mask, pipeline registers, adder trees and accumulators.

## Test plan
- Defaults, mode 0; v all 1; row0 all 1, row1 all 2^W-1, row2 all 0; 100 beats back-to-back -> res_data = {0, 7492, 700}; res_valid 3 cycles after beat 99.
- Same stimulus, mode 1 -> {0, 700, 7492}.
- W=8, N=700, all products +1 -> channel result 700 mod 256 = 188 (wrap).
- N=701, P=7: 101 beats, all lanes driven 1 including the 6 out-of-range lanes on the last beat -> 701 per all-1 row.
- v_valid toggles every other cycle; res_ready held low 5 cycles; start pulsed while busy -> same values as scenario 1, res_data stable while stalled, start ignored.
- en asserted at beat 50 -> next cycle v_ready=0, busy=0; a fresh run of scenario 1 then returns {0, 7492, 700}.
